issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Parametrised load-use hazard scoreboard and LL/SC reservation tracker for the ID stage.
//  Generalises single-cycle load-use stall detection to arbitrary load latency via per-register
//  countdown counters. Also provides the stateful LL/SC link flag that feeds atomic_id and
//  mem_sc_mask_id. Sits beside decode. It takes decoded register usage in and returns stall,
//  issue and atomic status.
// PARAMETERS
//  NUM_REGS    32  architectural registers; register 0 is hardwired zero and is never tracked
//  ADDR_W      5   register address width, equal to clog2(NUM_REGS)
//  LOAD_LAT    1   cycles after load issue before its data is forwardable; legal range 1..7
//  CNT_W       3   counter width, at least clog2(LOAD_LAT+1)
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous reset, active-high
//  id_valid      in   1         ID holds a valid instruction
//  id_flush      in   1         kill the ID instruction this cycle (branch/jump redirect)
//  rs_addr       in   ADDR_W    source register 1
//  rs_used       in   1         instruction reads rs
//  rt_addr       in   ADDR_W    source register 2
//  rt_used       in   1         instruction reads rt
//  dst_addr      in   ADDR_W    destination register
//  dst_we        in   1         instruction writes dst_addr
//  dst_is_load   in   1         destination value comes from memory (LB/LBU/LW/LL)
//  is_ll         in   1         instruction is LL
//  is_sc         in   1         instruction is SC
//  is_store      in   1         instruction is SW/SB (not SC)
//  ll_invalidate in   1         external reservation kill (snoop write, exception, ERET)
//  stall         out  1         hold PC/IF/ID and insert a bubble into EX
//  issue         out  1         ID instruction advances to EX this cycle
//  atomic        out  1         link flag (drives atomic_id)
//  sc_fail       out  1         SC in ID must not store and writes 0 to rt (drives mem_sc_mask_id)
//  pending       out  NUM_REGS  bit r = cnt[r] != 0 (debug/verification visibility)
// BEHAVIOUR
//  State:
//   cnt[1..NUM_REGS-1], each CNT_W bits.
//   link FSM with states UNLINKED and LINKED; atomic = (state == LINKED).
//  Combinational outputs:
//   hz_rs = rs_used & rs_addr!=0 & cnt[rs_addr]!=0; hz_rt is defined the same way for rt.
//   stall = id_valid & ~id_flush & (hz_rs | hz_rt).
//   issue = id_valid & ~id_flush & ~stall.
//   sc_fail = is_sc & ~atomic. Combinational; it does not consider ll_invalidate in the same cycle.
//  Counters, updated per clock:
//   Any cnt[r] != 0 decrements by 1.
//   If issue & dst_we & dst_addr!=0, then cnt[dst_addr] <= dst_is_load ? LOAD_LAT : 0.
//   Issue write wins over decrement on the same register (WAW: the younger writer's latency replaces the older one).
//   An ALU result is forwardable the next cycle, so it never stalls.
//   With LOAD_LAT=1 a dependent instruction stalls exactly 1 cycle, matching the existing single-stall behaviour.
//   Stalls never touch counters except through decrement, so a stall lasts exactly the remaining count.
//   Flush does not clear counters: older in-flight loads still complete.
//  Link FSM, priority high to low:
//   rst                      -> UNLINKED
//   ll_invalidate            -> UNLINKED
//   issue & (is_sc|is_store) -> UNLINKED
//   issue & is_ll            -> LINKED
//   otherwise hold.
//   An LL that is stalled or flushed does not link. An SC that is stalled holds state until it issues.
//  Reset: all cnt = 0, state UNLINKED, hence stall=0, atomic=0, pending=0, sc_fail=is_sc.
//   issue follows id_valid & ~id_flush.
//  Reset mid-stall: stall drops in the cycle after rst is sampled high.
//   Any in-flight load is considered retired by the pipeline reset.
// TESTING
//  T1 LOAD_LAT=1: LW r5, then ADDU r6,r5,r5 on the next cycle -> stall=1 for 1 cycle, issue=1 on the 2nd.
//  T2 LOAD_LAT=3: LW r5, then a dependent instruction -> stall=1 for 3 cycles, pending[5] deasserts on cycle 4.
//  T3 WAW: LW r7 (LOAD_LAT=3), then ADDU r7 next cycle, then a reader of r7 -> the reader does not stall, cnt[7]=0.
//  T4 Register 0 and unused sources: LW r0, then a reader of r0 -> no stall; rs_used=0 on a pending rs -> no stall.
//  T5 LL/SC: LL issue -> atomic=1; SC -> sc_fail=0. LL, SW, then SC -> sc_fail=1. LL, ll_invalidate, then SC -> sc_fail=1.
//  T6 Flush and reset: LL with id_flush=1 -> atomic stays 0. rst asserted during a 3-cycle stall -> stall=0 next cycle, pending=0.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Load-use hazard scoreboard with per-register latency counters
// and the LL/SC link flag for the ID stage.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_flush,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic                rs_used,
  input  logic [ADDR_W-1:0]   rt_addr,
  input  logic                rt_used,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic                dst_we,
  input  logic                dst_is_load,
  input  logic                is_ll,
  input  logic                is_sc,
  input  logic                is_store,
  input  logic                ll_invalidate,
  output logic                stall,
  output logic                issue,
  output logic                atomic,
  output logic                sc_fail,
  output logic [NUM_REGS-1:0] pending
);

  typedef enum logic {
    UNLINKED = 1'b0,
    LINKED   = 1'b1
  } link_e;

  link_e            link_q, link_d;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             hz_rs, hz_rt, wr_en;

  // Source hazards: a read of a register whose load data is not yet forwardable.
  always_comb begin
    hz_rs = rs_used && (rs_addr != '0)
         && (cnt_q[rs_addr] != '0);
    hz_rt = rt_used && (rt_addr != '0)
         && (cnt_q[rt_addr] != '0);
  end

  assign stall   = id_valid & ~id_flush & (hz_rs | hz_rt);
  assign issue   = id_valid & ~id_flush & ~stall;
  assign atomic  = (link_q == LINKED);
  assign sc_fail = is_sc & ~atomic;
  assign wr_en   = issue & dst_we & (dst_addr != '0);

  // Countdown per register; an issuing writer overrides the decrement (WAW).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
      if (r != 0) begin
        if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        if (wr_en && (int'(dst_addr) == r))
          cnt_d[r] = dst_is_load ? CNT_W'(LOAD_LAT) : '0;
      end
    end
  end

  // Counter registers; reset retires every in-flight load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  // Debug view of which registers still have a load outstanding.
  always_comb begin
    pending = '0;
    for (int r = 1; r < NUM_REGS; r++)
      pending[r] = (cnt_q[r] != '0);
  end

  // Link next state: invalidate beats SC/store kill, which beats LL link.
  always_comb begin
    link_d = link_q;
    if (ll_invalidate)
      link_d = UNLINKED;
    else if (issue && (is_sc || is_store))
      link_d = UNLINKED;
    else if (issue && is_ll)
      link_d = LINKED;
  end

  // Link state register.
  always_ff @(posedge clk) begin
    if (rst) link_q <= UNLINKED;
    else     link_q <= link_d;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 instances
// share stimulus and are checked against a ready-time model.
module tb_issue_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_flush;
  logic [4:0] rs_addr, rt_addr, dst_addr;
  logic rs_used, rt_used, dst_we, dst_is_load;
  logic is_ll, is_sc, is_store, ll_invalidate;

  logic        stall_o   [2];
  logic        issue_o   [2];
  logic        atomic_o  [2];
  logic        scf_o     [2];
  logic [31:0] pend_o    [2];

  int checks = 0;
  int failures = 0;

  // model: cycle at which each register's value becomes usable
  int  rdy [2][32];
  bit  lnk [2];
  int  lat [2] = '{1, 3};
  int  now = 0;

  bit          e_stall [2];
  bit          e_issue [2];
  bit          e_atomic[2];
  bit          e_scf   [2];
  logic [31:0] e_pend  [2];

  always #5 clk = ~clk;

  issue_scoreboard #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush),
    .rs_addr(rs_addr), .rs_used(rs_used),
    .rt_addr(rt_addr), .rt_used(rt_used),
    .dst_addr(dst_addr), .dst_we(dst_we),
    .dst_is_load(dst_is_load),
    .is_ll(is_ll), .is_sc(is_sc),
    .is_store(is_store),
    .ll_invalidate(ll_invalidate),
    .stall(stall_o[0]), .issue(issue_o[0]),
    .atomic(atomic_o[0]), .sc_fail(scf_o[0]),
    .pending(pend_o[0])
  );

  issue_scoreboard #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush),
    .rs_addr(rs_addr), .rs_used(rs_used),
    .rt_addr(rt_addr), .rt_used(rt_used),
    .dst_addr(dst_addr), .dst_we(dst_we),
    .dst_is_load(dst_is_load),
    .is_ll(is_ll), .is_sc(is_sc),
    .is_store(is_store),
    .ll_invalidate(ll_invalidate),
    .stall(stall_o[1]), .issue(issue_o[1]),
    .atomic(atomic_o[1]), .sc_fail(scf_o[1]),
    .pending(pend_o[1])
  );

  task automatic put(
    input bit v, fl,
    input int rs, input bit rsu,
    input int rt, input bit rtu,
    input int dst, input bit we, ld,
    input bit ll, sc, st, inv
  );
    id_valid = v;       id_flush = fl;
    rs_addr = 5'(rs);   rs_used = rsu;
    rt_addr = 5'(rt);   rt_used = rtu;
    dst_addr = 5'(dst); dst_we = we;
    dst_is_load = ld;
    is_ll = ll; is_sc = sc; is_store = st;
    ll_invalidate = inv;
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      lnk[i] = 0;
      for (int r = 0; r < 32; r++) rdy[i][r] = 0;
    end
  endtask

  // settle inputs and compute expected outputs for this cycle
  task automatic eval();
    bit hr, ht;
    #1;
    for (int i = 0; i < 2; i++) begin
      hr = rs_used && rs_addr != 0
        && rdy[i][rs_addr] > now;
      ht = rt_used && rt_addr != 0
        && rdy[i][rt_addr] > now;
      e_stall[i]  = id_valid && !id_flush && (hr || ht);
      e_issue[i]  = id_valid && !id_flush && !e_stall[i];
      e_atomic[i] = lnk[i];
      e_scf[i]    = is_sc && !lnk[i];
      for (int r = 0; r < 32; r++)
        e_pend[i][r] = (r != 0) && (rdy[i][r] > now);
    end
  endtask

  // apply this cycle's effects to the model, then move to next cycle
  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        lnk[i] = 0;
        for (int r = 0; r < 32; r++) rdy[i][r] = 0;
      end else begin
        if (e_issue[i] && dst_we && dst_addr != 0)
          rdy[i][dst_addr] = now + 1
            + (dst_is_load ? lat[i] : 0);
        if (ll_invalidate)
          lnk[i] = 0;
        else if (e_issue[i] && (is_sc || is_store))
          lnk[i] = 0;
        else if (e_issue[i] && is_ll)
          lnk[i] = 1;
      end
    end
    now++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      idle(); eval(); advance();
    end
  endtask

  task automatic test_reset();
    idle();
    id_valid = 1; is_sc = 1;
    eval();
    for (int i = 0; i < 2; i++) begin
      checks += 5;
      if (stall_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_stall[%0d] got=%b exp=0", i, stall_o[i]);
      end
      if (issue_o[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_issue[%0d] got=%b exp=1", i, issue_o[i]);
      end
      if (atomic_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_atomic[%0d] got=%b exp=0", i, atomic_o[i]);
      end
      if (scf_o[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_scfail[%0d] got=%b exp=1", i, scf_o[i]);
      end
      if (pend_o[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_pending[%0d] got=%h exp=0", i, pend_o[i]);
      end
    end
    is_sc = 0;
    advance();
  endtask

  task automatic test_load_use();
    int ns [2] = '{0, 0};
    put(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    eval(); advance();
    for (int k = 0; k < 5; k++) begin
      put(1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      eval();
      for (int i = 0; i < 2; i++) begin
        if (stall_o[i] === 1'b1) ns[i]++;
        checks += 3;
        if (stall_o[i] !== e_stall[i]) begin
          failures++;
          $display("FAIL lu_stall[%0d] k=%0d got=%b exp=%b", i, k, stall_o[i], e_stall[i]);
        end
        if (issue_o[i] !== e_issue[i]) begin
          failures++;
          $display("FAIL lu_issue[%0d] k=%0d got=%b exp=%b", i, k, issue_o[i], e_issue[i]);
        end
        if (pend_o[i][5] !== e_pend[i][5]) begin
          failures++;
          $display("FAIL lu_pend5[%0d] k=%0d got=%b exp=%b", i, k, pend_o[i][5], e_pend[i][5]);
        end
      end
      advance();
    end
    checks += 2;
    if (ns[0] != 1) begin
      failures++;
      $display("FAIL lu_len_lat1 got=%0d exp=1", ns[0]);
    end
    if (ns[1] != 3) begin
      failures++;
      $display("FAIL lu_len_lat3 got=%0d exp=3", ns[1]);
    end
    drain(4);
  endtask

  task automatic test_waw();
    put(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    eval(); advance();
    put(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    eval(); advance();
    put(1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (stall_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL waw_stall[%0d] got=%b exp=0", i, stall_o[i]);
      end
      if (pend_o[i][7] !== 1'b0) begin
        failures++;
        $display("FAIL waw_pend7[%0d] got=%b exp=0", i, pend_o[i][7]);
      end
    end
    advance();
    drain(4);
  endtask

  task automatic test_r0_unused();
    put(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    eval(); advance();
    put(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    eval();
    checks += 2;
    if (stall_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL r0_stall got=%b exp=0", stall_o[1]);
    end
    if (pend_o[1] !== 32'h0) begin
      failures++;
      $display("FAIL r0_pending got=%h exp=0", pend_o[1]);
    end
    advance();
    put(1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    eval(); advance();
    put(1, 0, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    checks += 2;
    if (pend_o[1][9] !== 1'b1) begin
      failures++;
      $display("FAIL unused_pend9 got=%b exp=1", pend_o[1][9]);
    end
    if (stall_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL unused_stall got=%b exp=0", stall_o[1]);
    end
    advance();
    drain(4);
  endtask

  task automatic test_llsc();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    eval(); advance();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    eval();
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (atomic_o[i] !== 1'b1) begin
        failures++;
        $display("FAIL ll_atomic[%0d] got=%b exp=1", i, atomic_o[i]);
      end
      if (scf_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL ll_sc_ok[%0d] got=%b exp=0", i, scf_o[i]);
      end
    end
    advance();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    eval(); advance();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    eval(); advance();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    eval();
    checks++;
    if (scf_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL sw_kill_scfail got=%b exp=1", scf_o[1]);
    end
    advance();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    eval(); advance();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    eval(); advance();
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    eval();
    checks += 2;
    if (scf_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL inv_scfail got=%b exp=1", scf_o[1]);
    end
    if (atomic_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL inv_atomic got=%b exp=0", atomic_o[1]);
    end
    advance();
  endtask

  task automatic test_flush_reset();
    put(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    eval(); advance();
    idle(); eval();
    checks++;
    if (atomic_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL flush_ll_atomic got=%b exp=0", atomic_o[1]);
    end
    advance();
    put(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    eval(); advance();
    put(1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval(); advance();
    rst = 1;
    eval();
    checks++;
    if (stall_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_stall got=%b exp=1", stall_o[1]);
    end
    advance();
    rst = 0;
    eval();
    checks += 3;
    if (stall_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall got=%b exp=0", stall_o[1]);
    end
    if (issue_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_issue got=%b exp=1", issue_o[1]);
    end
    if (pend_o[1] !== 32'h0) begin
      failures++;
      $display("FAIL rst_pending got=%h exp=0", pend_o[1]);
    end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      put($urandom_range(9, 0) < 8, $urandom_range(9, 0) == 0,
          $urandom_range(7, 0), $urandom_range(1, 0),
          $urandom_range(7, 0), $urandom_range(1, 0),
          $urandom_range(7, 0), $urandom_range(3, 0) != 0,
          $urandom_range(1, 0),
          $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0,
          $urandom_range(7, 0) == 0, $urandom_range(19, 0) == 0);
      rst = ($urandom_range(49, 0) == 0);
      eval();
      for (int i = 0; i < 2; i++) begin
        checks += 5;
        if (stall_o[i] !== e_stall[i]) begin
          failures++;
          $display("FAIL rnd_stall[%0d] n=%0d got=%b exp=%b", i, n, stall_o[i], e_stall[i]);
        end
        if (issue_o[i] !== e_issue[i]) begin
          failures++;
          $display("FAIL rnd_issue[%0d] n=%0d got=%b exp=%b", i, n, issue_o[i], e_issue[i]);
        end
        if (atomic_o[i] !== e_atomic[i]) begin
          failures++;
          $display("FAIL rnd_atomic[%0d] n=%0d got=%b exp=%b", i, n, atomic_o[i], e_atomic[i]);
        end
        if (scf_o[i] !== e_scf[i]) begin
          failures++;
          $display("FAIL rnd_scfail[%0d] n=%0d got=%b exp=%b", i, n, scf_o[i], e_scf[i]);
        end
        if (pend_o[i] !== e_pend[i]) begin
          failures++;
          $display("FAIL rnd_pending[%0d] n=%0d got=%h exp=%h", i, n, pend_o[i], e_pend[i]);
        end
      end
      advance();
    end
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
    test_reset();
    test_load_use();
    test_waw();
    test_r0_unused();
    test_llsc();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
